// File: rtl/ahb_lite_mmio_splitter.sv
// ahb_lite_mmio_splitter: AHB-Lite 1-to-N splitter for the processor MMIO port.
// Base/mask address decode (lowest index wins on overlap), data-phase tracking,
// read-data/response mux, internal default slave answering unmapped accesses with
// a two-cycle ERROR, and a saturating decode-error counter.
// Optional feature macro: AHB_TIMEOUT_EN. When defined, a slave that stalls for
// TIMEOUT_CYCLES consecutive cycles is abandoned, the master gets an ERROR pair,
// and TIMEOUT_FLAG sets (sticky until HRESET).
module ahb_lite_mmio_splitter #(
  parameter int unsigned                   NUM_SLAVES     = 4,
  parameter int unsigned                   ADDR_W         = 32,
  parameter int unsigned                   DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE       = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK       = {NUM_SLAVES{ADDR_W'(32'hFFFF_F000)}},
  parameter int unsigned                   ERR_CNT_W      = 8,
  parameter int unsigned                   TIMEOUT_CYCLES = 256
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  // Master side
  input  logic                         HSEL_M0,
  input  logic [ADDR_W-1:0]            HADDR_M0,
  input  logic [1:0]                   HTRANS_M0,
  input  logic                         HWRITE_M0,
  input  logic [2:0]                   HSIZE_M0,
  input  logic [2:0]                   HBURST_M0,
  input  logic [3:0]                   HPROT_M0,
  input  logic                         HMASTLOCK_M0,
  input  logic [DATA_W-1:0]            HWDATA_M0,
  output logic [DATA_W-1:0]            HRDATA_M0,
  output logic                         HREADY_M0,
  output logic                         HRESP_M0,
  // Slave side
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic [ADDR_W-1:0]            HADDR_S,
  output logic [1:0]                   HTRANS_S,
  output logic                         HWRITE_S,
  output logic [2:0]                   HSIZE_S,
  output logic [2:0]                   HBURST_S,
  output logic [3:0]                   HPROT_S,
  output logic                         HMASTLOCK_S,
  output logic [DATA_W-1:0]            HWDATA_S,
  output logic                         HREADYIN_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  // Status
  output logic [ERR_CNT_W-1:0]         DECODE_ERR_CNT,
  output logic                         TIMEOUT_FLAG
);

  localparam int unsigned SelW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {StIdle, StSlv, StErr1, StErr2} state_e;

  state_e                 state_q, state_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   hit_any;
  logic [SelW-1:0]        hit_idx;
  logic                   addr_valid;
  logic                   tmo_hit;

  // Broadcast address/control/write data to every slave
  assign HADDR_S     = HADDR_M0;
  assign HTRANS_S    = HTRANS_M0;
  assign HWRITE_S    = HWRITE_M0;
  assign HSIZE_S     = HSIZE_M0;
  assign HBURST_S    = HBURST_M0;
  assign HPROT_S     = HPROT_M0;
  assign HMASTLOCK_S = HMASTLOCK_M0;
  assign HWDATA_S    = HWDATA_M0;
  assign HREADYIN_S  = HREADY_M0;

  assign DECODE_ERR_CNT = err_cnt_q;

  // Priority decode: scan downwards so the lowest matching index is the one kept
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((HADDR_M0 & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_any = 1'b1;
        hit_idx = SelW'(i);
      end
    end
  end

  // One-hot slave select; independent of HTRANS, suppressed during reset
  always_comb begin
    HSEL_S = '0;
    if (!HRESET && HSEL_M0 && hit_any) begin
      HSEL_S[hit_idx] = 1'b1;
    end
  end

  // Master-facing response mux driven by the data-phase state
  always_comb begin
    HREADY_M0 = 1'b1;
    HRESP_M0  = 1'b0;
    HRDATA_M0 = '0;
    unique case (state_q)
      StSlv: begin
        HREADY_M0 = HREADYOUT_S[sel_q];
        HRESP_M0  = HRESP_S[sel_q];
        HRDATA_M0 = HRDATA_S[int'(sel_q)*DATA_W +: DATA_W];
      end
      StErr1: begin
        HREADY_M0 = 1'b0;
        HRESP_M0  = 1'b1;
      end
      StErr2: begin
        HREADY_M0 = 1'b1;
        HRESP_M0  = 1'b1;
      end
      default: begin
        HREADY_M0 = 1'b1;
        HRESP_M0  = 1'b0;
      end
    endcase
  end

  assign addr_valid = HSEL_M0 & HTRANS_M0[1] & HREADY_M0;

`ifdef AHB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_flag_q, tmo_flag_d;
  logic            stalled;

  // Count consecutive stalled slave cycles; fire on the TIMEOUT_CYCLES-th one
  always_comb begin
    stalled    = (state_q == StSlv) && !HREADYOUT_S[sel_q];
    tmo_hit    = stalled && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d  = (stalled && !tmo_hit) ? tmo_cnt_q + 1'b1 : '0;
    tmo_flag_d = tmo_flag_q | tmo_hit;
  end

  // Timeout counter and sticky flag
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign TIMEOUT_FLAG = tmo_flag_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign TIMEOUT_FLAG   = 1'b0;
`endif

  // Data-phase next state: ERR1->ERR2 always, otherwise advance only when HREADY_M0 is high
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_cnt_d = err_cnt_q;
    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (tmo_hit) begin
      // Abandon the stalled slave; its later outputs are no longer selected
      state_d = StErr1;
    end else if (HREADY_M0) begin
      if (addr_valid && hit_any) begin
        state_d = StSlv;
        sel_d   = hit_idx;
      end else if (addr_valid) begin
        state_d = StErr1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Data-phase state, active slave index and decode-error counter
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_mmio_splitter.sv
// Directed bench for ahb_lite_mmio_splitter: a transaction-level model tracks who owns
// the current data phase and is compared with the DUT on every falling edge, while
// literal expectations at key cycles pin the model.
module tb_ahb_lite_mmio_splitter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int EW  = 8;
  localparam int TMO = 16;
  localparam logic [N*AW-1:0] BASES = {32'h6000_3000, 32'h6000_2000,
                                       32'h6000_1000, 32'h6000_0000};
  localparam logic [N*AW-1:0] MASKS = {N{32'hFFFF_F000}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hsel, hwrite, hlock;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize, hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]  s_rdy, s_resp;

  logic [DW-1:0] HRDATA_M0;
  logic          HREADY_M0, HRESP_M0;
  logic [N-1:0]  HSEL_S;
  logic [AW-1:0] HADDR_S;
  logic [1:0]    HTRANS_S;
  logic          HWRITE_S, HMASTLOCK_S, HREADYIN_S;
  logic [2:0]    HSIZE_S, HBURST_S;
  logic [3:0]    HPROT_S;
  logic [DW-1:0] HWDATA_S;
  logic [EW-1:0] DECODE_ERR_CNT;
  logic          TIMEOUT_FLAG;

  ahb_lite_mmio_splitter #(
    .NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASES), .SLV_MASK(MASKS),
    .ERR_CNT_W(EW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .HCLK(clk), .HRESET(rst),
    .HSEL_M0(hsel), .HADDR_M0(haddr), .HTRANS_M0(htrans), .HWRITE_M0(hwrite),
    .HSIZE_M0(hsize), .HBURST_M0(hburst), .HPROT_M0(hprot), .HMASTLOCK_M0(hlock),
    .HWDATA_M0(hwdata), .HRDATA_M0(HRDATA_M0), .HREADY_M0(HREADY_M0), .HRESP_M0(HRESP_M0),
    .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S),
    .HSIZE_S(HSIZE_S), .HBURST_S(HBURST_S), .HPROT_S(HPROT_S), .HMASTLOCK_S(HMASTLOCK_S),
    .HWDATA_S(HWDATA_S), .HREADYIN_S(HREADYIN_S), .HRDATA_S(s_rdata),
    .HREADYOUT_S(s_rdy), .HRESP_S(s_resp),
    .DECODE_ERR_CNT(DECODE_ERR_CNT), .TIMEOUT_FLAG(TIMEOUT_FLAG)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: owner of the current data phase (-1 none, 0..N-1 slave, N internal error slave)
  int owner    = -1;
  int err_step = 0;
  int exp_cnt  = 0;
  bit exp_flag = 1'b0;
  int stall_n  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    logic [N*AW-1:0] b;
    logic [N*AW-1:0] m;
    b = BASES;
    m = MASKS;
    for (int i = 0; i < N; i++) begin
      if ((a & m[i*AW +: AW]) == b[i*AW +: AW]) return i;
    end
    return -1;
  endfunction

  // Compare against the model, then advance it as the clock edge will
  always @(negedge clk) begin
    logic         e_rdy, e_resp, rd_known, timed_out;
    logic [DW-1:0] e_rd;
    logic [N-1:0] e_sel;
    int           d;
    rd_known = 1'b1;
    e_rd     = '0;
    if (owner < 0) begin
      e_rdy = 1'b1; e_resp = 1'b0;
    end else if (owner < N) begin
      e_rdy = s_rdy[owner]; e_resp = s_resp[owner]; e_rd = s_rdata[owner*DW +: DW];
    end else begin
      e_rdy = (err_step == 2); e_resp = 1'b1; rd_known = 1'b0;
    end
    d = decode(haddr);
    e_sel = '0;
    if (!rst && hsel && d >= 0) e_sel[d] = 1'b1;
    if (chk_en) begin
      chk("m_hready", HREADY_M0, e_rdy);
      chk("m_hresp", HRESP_M0, e_resp);
      if (rd_known) chk("m_hrdata", HRDATA_M0, e_rd);
      chk("m_hsel_s", HSEL_S, e_sel);
      chk("m_hreadyin", HREADYIN_S, e_rdy);
      chk("m_errcnt", DECODE_ERR_CNT, exp_cnt);
      chk("m_tmoflag", TIMEOUT_FLAG, exp_flag);
      chk("m_bcast_ad", {HADDR_S, HWDATA_S}, {haddr, hwdata});
      chk("m_bcast_ctl", {HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HMASTLOCK_S},
          {htrans, hwrite, hsize, hburst, hprot, hlock});
    end
    timed_out = 1'b0;
    if (rst) begin
      owner = -1; err_step = 0; exp_cnt = 0; exp_flag = 1'b0; stall_n = 0;
    end else if (owner == N && err_step == 1) begin
      err_step = 2;
    end else begin
`ifdef AHB_TIMEOUT_EN
      if (owner >= 0 && owner < N && !e_rdy) begin
        stall_n++;
        if (stall_n == TMO) begin
          timed_out = 1'b1; stall_n = 0; owner = N; err_step = 1; exp_flag = 1'b1;
        end
      end else begin
        stall_n = 0;
      end
`endif
      if (!timed_out && e_rdy) begin
        if (hsel && htrans[1]) begin
          if (d >= 0) owner = d;
          else begin
            owner = N; err_step = 1;
            if (exp_cnt < 255) exp_cnt++;
          end
        end else begin
          owner = -1;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic addr(input logic [AW-1:0] a, input logic w);
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    hsel = 0; haddr = '0; htrans = 2'b00; hwrite = 0; hsize = 3'b010; hburst = 3'b000;
    hprot = 4'b0011; hlock = 0; hwdata = '0; s_rdy = '1; s_resp = '0;
    for (int i = 0; i < N; i++) s_rdata[i*DW +: DW] = 32'hCAFE_0000 + i;
    rst = 1'b1;
    nxt(); chk_en = 1'b1;
    nxt(); rst = 1'b0;

    // Reset state
    neg();
    chk("rst_hready", HREADY_M0, 1'b1); chk("rst_hresp", HRESP_M0, 1'b0);
    chk("rst_hrdata", HRDATA_M0, 32'h0); chk("rst_cnt", DECODE_ERR_CNT, 8'd0);
    chk("rst_flag", TIMEOUT_FLAG, 1'b0);
    nxt();

    // Read slave1 with two wait states
    addr(32'h6000_1004, 1'b0); neg(); chk("t1_hsel", HSEL_S, 4'b0010); nxt();
    idle(); s_rdy[1] = 1'b0; neg(); chk("t1_wait1", HREADY_M0, 1'b0); nxt();
    neg(); chk("t1_wait2", HREADY_M0, 1'b0); nxt();
    s_rdy[1] = 1'b1; neg();
    chk("t1_ready", HREADY_M0, 1'b1); chk("t1_rdata", HRDATA_M0, 32'hCAFE_0001);
    chk("t1_resp", HRESP_M0, 1'b0);
    nxt();

    // Back-to-back write slave0, read slave3
    addr(32'h6000_0000, 1'b1); neg(); chk("t2_hsel0", HSEL_S, 4'b0001); nxt();
    addr(32'h6000_3010, 1'b0); hwdata = 32'h1234_5678; neg();
    chk("t2_hsel3", HSEL_S, 4'b1000); chk("t2_wr_rdy", HREADY_M0, 1'b1); nxt();
    idle(); neg();
    chk("t2_rd_rdy", HREADY_M0, 1'b1); chk("t2_rdata", HRDATA_M0, 32'hCAFE_0003); nxt();

    // Unmapped access: two-cycle ERROR, counter 0 -> 1
    addr(32'h7000_0000, 1'b0); neg(); chk("t3_nosel", HSEL_S, 4'b0000); nxt();
    idle(); neg();
    chk("t3_err1", {HREADY_M0, HRESP_M0}, 2'b01); chk("t3_cnt", DECODE_ERR_CNT, 8'd1); nxt();
    neg(); chk("t3_err2", {HREADY_M0, HRESP_M0}, 2'b11); nxt();
    neg(); chk("t3_idle", {HREADY_M0, HRESP_M0}, 2'b10); nxt();

    // Address held through ERR1, cancelled with IDLE in ERR2, then OKAY to slave2
    addr(32'h7000_0000, 1'b0); nxt();
    neg(); chk("t4_err1", {HREADY_M0, HRESP_M0}, 2'b01); nxt();
    idle(); neg(); chk("t4_err2", {HREADY_M0, HRESP_M0}, 2'b11); nxt();
    addr(32'h6000_2000, 1'b0); neg();
    chk("t4_back_idle", {HREADY_M0, HRESP_M0}, 2'b10); chk("t4_cnt", DECODE_ERR_CNT, 8'd2);
    chk("t4_hsel2", HSEL_S, 4'b0100); nxt();
    idle(); neg();
    chk("t4_okay", {HREADY_M0, HRESP_M0}, 2'b10); chk("t4_rdata", HRDATA_M0, 32'hCAFE_0002);
    nxt();

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      addr(32'h7000_0000, 1'b0); nxt();
      idle(); nxt();
      nxt();
    end
    neg(); chk("sat_cnt", DECODE_ERR_CNT, 8'd255); nxt();

    // BUSY is selected but not decoded into a data phase
    hsel = 1'b1; haddr = 32'h6000_0000; htrans = 2'b01; s_rdy[0] = 1'b0;
    neg(); chk("busy_hsel", HSEL_S, 4'b0001); nxt();
    idle(); neg(); chk("busy_nodp", HREADY_M0, 1'b1); nxt();
    s_rdy[0] = 1'b1;

    // Reset while slave2 stalls
    addr(32'h6000_2000, 1'b0); nxt();
    idle(); s_rdy[2] = 1'b0; neg(); chk("t5_stall", HREADY_M0, 1'b0); nxt();
    rst = 1'b1; neg(); chk("t5_rst_sel", HSEL_S, 4'b0000); nxt();
    rst = 1'b0; neg();
    chk("t5_hready", HREADY_M0, 1'b1); chk("t5_hresp", HRESP_M0, 1'b0);
    chk("t5_cnt", DECODE_ERR_CNT, 8'd0); chk("t5_flag", TIMEOUT_FLAG, 1'b0);
    nxt();
    s_rdy[2] = 1'b1;

    // Slave0 stalls
    addr(32'h6000_0000, 1'b0); nxt();
    idle(); s_rdy[0] = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      neg();
      if (k == TMO) chk("t6_stall16", {HREADY_M0, HRESP_M0}, 2'b00);
      nxt();
    end
`ifdef AHB_TIMEOUT_EN
    neg(); chk("t6_tmo_err1", {HREADY_M0, HRESP_M0}, 2'b01); nxt();
    neg(); chk("t6_tmo_err2", {HREADY_M0, HRESP_M0}, 2'b11);
    chk("t6_flag", TIMEOUT_FLAG, 1'b1); nxt();
    neg(); chk("t6_after", {HREADY_M0, HRESP_M0, TIMEOUT_FLAG}, 3'b101); nxt();
    s_rdy[0] = 1'b1; rst = 1'b1; nxt();
    rst = 1'b0; neg(); chk("t6_flag_clr", TIMEOUT_FLAG, 1'b0); nxt();
`else
    for (int k = 0; k < 24; k++) nxt();
    neg(); chk("t6_still_stall", HREADY_M0, 1'b0); chk("t6_noflag", TIMEOUT_FLAG, 1'b0);
    nxt();
    s_rdy[0] = 1'b1; neg();
    chk("t6_release", HREADY_M0, 1'b1); chk("t6_rdata", HRDATA_M0, 32'hCAFE_0000); nxt();
`endif
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
